ciphertext_drain: RTL and testbench
===================================

// Module: ciphertext_drain
// PURPOSE
//  Downstream of the round pipeline. After the last round, moves N finished 128-bit state blocks
//  from the shared working SRAM into a small output FIFO. The AMBA read path pops blocks from the FIFO.
//  It frees the SRAM for the next key/data load while the master is still draining results.
//  It is one more master on the OR-combined SRAM bus.
// PARAMETERS
//  DEPTH      4        FIFO entries (power of 2, >=2)
//  BASE_ADDR  16'h0010 SRAM address of block 0; block i is at BASE_ADDR+i
//  ADDR_W     16       SRAM address width
//  DATA_W     128      block width
// PORTS
//  clk            in   1       system clock
//  n_rst          in   1       async active-low reset
//  drain_enable   in   1       1-cycle start pulse from controller
//  nblocks        in   4       blocks to drain, sampled on drain_enable
//  sramReadValue  in   DATA_W  shared SRAM read data, valid in the cycle sramRead=1
//  sramRead       out  1       SRAM read strobe
//  sramWrite      out  1       SRAM write strobe (scrub only)
//  sramAddr       out  ADDR_W  SRAM address
//  sramWriteValue out  DATA_W  SRAM write data
//  out_valid      out  1       FIFO head valid
//  out_data       out  DATA_W  FIFO head block
//  out_ready      in   1       consumer pop; pop = out_valid & out_ready
//  fifo_count     out  log2(DEPTH)+1  occupancy
//  busy           out  1       FSM not IDLE
//  drain_finished out  1       1-cycle pulse, all blocks captured (and scrubbed)
//  start_err      out  1       1-cycle pulse, drain_enable seen while busy
// BEHAVIOUR
//  Clock and reset
//  - Single clock (clk); async active-low reset (n_rst).
//  - Reset values: all outputs 0, FIFO empty, FSM=IDLE, block index=0.
//  - Reset mid-drain aborts the drain: FIFO contents are discarded and no finished pulse is issued.
//  SRAM bus
//  - sramRead, sramWrite, sramAddr and sramWriteValue are all 0 whenever this block is not
//    accessing the SRAM. The bus is OR-combined, so any nonzero idle value corrupts other masters.
//  State machine (IDLE, WAIT, READ, SCRUB, DONE)
//  - IDLE, drain_enable=1: latch nblocks, idx<=0.
//      nblocks==0 -> DONE.
//      Otherwise  -> WAIT.
//  - WAIT: if fifo_count<DEPTH (registered value) -> READ; else stay in WAIT.
//      A pop in the same cycle does not unblock WAIT until the next cycle.
//  - READ: sramRead=1, sramAddr=BASE_ADDR+idx.
//      sramReadValue is pushed into the FIFO at the edge that ends READ.
//      Next state: SCRUB if enabled; else idx+1 and DONE if last block, otherwise WAIT.
//  - SCRUB: see CONFIGURATION.
//  - DONE: drain_finished=1 for one cycle -> IDLE.
//  - drain_enable outside IDLE is ignored and pulses start_err.
//  Latency and throughput
//  - Without scrub, a non-full FIFO gives 2 cycles per block (WAIT+READ).
//  - The first read is issued 2 cycles after drain_enable.
//  FIFO
//  - Push and pop in the same cycle leave the count unchanged.
//  - Pop on empty is a no-op.
//  - Push on full cannot occur (guarded by WAIT).
//  - Pointers wrap modulo DEPTH.
//  - out_data is the head entry, registered; first-word latency is 1 cycle after the push edge.
//  Arithmetic
//  - Address = BASE_ADDR + zero-extended idx, truncated to ADDR_W (wraps at 2^ADDR_W).
// CONFIGURATION
//  - Macro DRAIN_SCRUB_EN:
//      Defined: SCRUB state is present. For one cycle after each READ: sramWrite=1,
//        sramAddr=the same address, sramWriteValue=0. This wipes the ciphertext from the SRAM.
//        Throughput is 3 cycles per block.
//      Undefined: SCRUB is absent; sramWrite and sramWriteValue are tied to 0.
// STRUCTURE
//  - aes_pkg: drain_state_t enum, SRAM_ADDR_W=16, AES_BLOCK_W=128.
//  - Sub-module drain_fifo (parameterised DEPTH/width synchronous FIFO).
//    Exposes push, pop, count, head.
//  - FSM, address generation and scrub logic live in ciphertext_drain.
// TESTING
//  - Basic drain:
//      Preload SRAM 0x10..0x12 with A,B,C. Pulse drain_enable with nblocks=3, out_ready=1.
//      -> sramRead at addr 0x10/0x11/0x12.
//      -> out_data sequence A,B,C.
//      -> drain_finished 1 pulse; busy=0 afterwards.
//  - Backpressure:
//      DEPTH=4, nblocks=6, out_ready=0. -> fifo_count stops at 4; FSM holds in WAIT.
//      Then raise out_ready. -> all 6 blocks are delivered in order; finished pulse follows.
//  - Zero and error:
//      nblocks=0 -> drain_finished 2 cycles after start, no sramRead.
//      drain_enable while busy -> start_err pulse; the current drain is unaffected.
//  - Bus hygiene:
//      In every cycle outside READ/SCRUB -> sramRead, sramWrite, sramAddr, sramWriteValue all 0.
//  - Reset mid-drain:
//      Assert n_rst after 1 of 3 blocks. -> outputs 0 immediately; fifo_count=0; no finished pulse.
//  - DRAIN_SCRUB_EN:
//      nblocks=2 -> each READ is followed by a write of 0 to the same address.
//      -> SRAM 0x10 and 0x11 read back as 0; FIFO still holds the original data.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and widths for the ciphertext drain path.
package aes_pkg;
    localparam int unsigned SRAM_ADDR_W = 16;
    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned NBLK_W      = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRead,
        StScrub,
        StDone
    } drain_state_t;
endpackage

// File: rtl/drain_fifo.sv
// Small synchronous FIFO with a registered head word; DEPTH must be a power of two.
module drain_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     valid,
    output logic [WIDTH-1:0]         head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign do_push = push && (count_q < CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        // The incoming word becomes the head when the FIFO is, or is about to be, empty.
        if (count_d == '0) begin
            head_d = '0;
        end else if (count_q == '0 || (do_pop && count_q == CNT_W'(1))) begin
            head_d = wdata;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count = count_q;
    assign valid = (count_q != '0);
    assign head  = head_q;
endmodule

// File: rtl/ciphertext_drain.sv
// Moves finished blocks from the shared SRAM into an output FIFO.
// Define DRAIN_SCRUB_EN to zero each SRAM block right after it is read.
module ciphertext_drain
    import aes_pkg::*;
#(
    parameter int unsigned          DEPTH     = 4,
    parameter int unsigned          ADDR_W    = SRAM_ADDR_W,
    parameter int unsigned          DATA_W    = AES_BLOCK_W,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = 16'h0010
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    drain_enable,
    input  logic [NBLK_W-1:0]       nblocks,
    input  logic [DATA_W-1:0]       sramReadValue,
    output logic                    sramRead,
    output logic                    sramWrite,
    output logic [ADDR_W-1:0]       sramAddr,
    output logic [DATA_W-1:0]       sramWriteValue,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    busy,
    output logic                    drain_finished,
    output logic                    start_err
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    drain_state_t      state_q, state_d;
    logic [NBLK_W-1:0] idx_q, idx_d, nblk_q, nblk_d;
    logic              rd_q, rd_d, fin_q, fin_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              push, last, access_d;

    assign last = ({1'b0, idx_q} + 5'd1) == {1'b0, nblk_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nblk_d  = nblk_q;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                if (drain_enable) begin
                    nblk_d  = nblocks;
                    idx_d   = '0;
                    state_d = (nblocks == '0) ? StDone : StWait;
                end
            end
            StWait: begin
                if (fifo_count < CNT_W'(DEPTH)) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                push = 1'b1;
`ifdef DRAIN_SCRUB_EN
                state_d = StScrub;
`else
                idx_d   = idx_q + NBLK_W'(1);
                state_d = last ? StDone : StWait;
`endif
            end
`ifdef DRAIN_SCRUB_EN
            StScrub: begin
                idx_d   = idx_q + NBLK_W'(1);
                state_d = last ? StDone : StWait;
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Bus outputs are registered against the next state so they line up with it exactly.
        access_d = (state_d == StRead) || (state_d == StScrub);
        rd_d     = (state_d == StRead);
        addr_d   = access_d ? (BASE_ADDR + ADDR_W'(idx_d)) : '0;
        fin_d    = (state_q == StDone);
        err_d    = drain_enable && (state_q != StIdle);
    end

`ifdef DRAIN_SCRUB_EN
    logic wr_q;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_q <= 1'b0;
        end else begin
            wr_q <= (state_d == StScrub);
        end
    end
    assign sramWrite = wr_q;
`else
    assign sramWrite = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            nblk_q  <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nblk_q  <= nblk_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
        end
    end

    drain_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push),
        .wdata (sramReadValue),
        .pop   (out_ready),
        .count (fifo_count),
        .valid (out_valid),
        .head  (out_data)
    );

    assign sramRead       = rd_q;
    assign sramAddr       = addr_q;
    assign sramWriteValue = '0;
    assign busy           = (state_q != StIdle);
    assign drain_finished = fin_q;
    assign start_err      = err_q;
endmodule

// File: tb/tb_ciphertext_drain.sv
// Directed bench for ciphertext_drain with a behavioural SRAM; honours DRAIN_SCRUB_EN.
module tb_ciphertext_drain;
    logic         clk = 1'b0;
    logic         n_rst;
    logic         drain_enable;
    logic [3:0]   nblocks;
    logic [127:0] sramReadValue;
    logic         sramRead, sramWrite;
    logic [15:0]  sramAddr;
    logic [127:0] sramWriteValue;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;
    logic [2:0]   fifo_count;
    logic         busy, drain_finished, start_err;

    int checks = 0;
    int errors = 0;

    logic [127:0] sram [256];
    logic [15:0]  rd_log [$];
    logic [15:0]  wr_log [$];
    logic [127:0] pop_log [$];
    int           fin_cnt = 0;

    always #5 clk = ~clk;

    ciphertext_drain u_dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .drain_enable   (drain_enable),
        .nblocks        (nblocks),
        .sramReadValue  (sramReadValue),
        .sramRead       (sramRead),
        .sramWrite      (sramWrite),
        .sramAddr       (sramAddr),
        .sramWriteValue (sramWriteValue),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .fifo_count     (fifo_count),
        .busy           (busy),
        .drain_finished (drain_finished),
        .start_err      (start_err)
    );

    assign sramReadValue = sramRead ? sram[sramAddr[7:0]] : '0;

    always @(posedge clk) begin
        if (sramWrite) sram[sramAddr[7:0]] <= sramWriteValue;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Per-cycle monitor: bus hygiene plus logs of reads, scrubs, pops and finish pulses.
    always @(negedge clk) begin
        if (n_rst) begin
            if (!sramRead && !sramWrite) begin
                check("idle_bus", 128'(sramAddr) | sramWriteValue, '0);
            end
`ifndef DRAIN_SCRUB_EN
            check("no_write", 128'(sramWrite), '0);
`endif
            if (sramRead) rd_log.push_back(sramAddr);
            if (sramWrite) wr_log.push_back(sramAddr);
            if (out_valid && out_ready) pop_log.push_back(out_data);
            if (drain_finished) fin_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] n);
        drain_enable = 1'b1;
        nblocks      = n;
        tick();
        drain_enable = 1'b0;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        pop_log.delete();
    endtask

    task automatic preload(input logic [127:0] base);
        for (int i = 0; i < 8; i++) sram[16 + i] <= base + 128'(i);
    endtask

    task automatic wait_finish(input int bound);
        int f0;
        f0 = fin_cnt;
        for (int i = 0; i < bound && fin_cnt == f0; i++) tick();
        check("finish_seen", 128'(fin_cnt - f0), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int f0;
        n_rst        = 1'b0;
        drain_enable = 1'b0;
        nblocks      = '0;
        out_ready    = 1'b0;
        for (int i = 0; i < 256; i++) sram[i] <= {8{16'(i)}};
        tick();
        tick();
        check("rst_bus", 128'({sramRead, sramWrite, sramAddr}) | sramWriteValue, '0);
        check("rst_fifo", 128'({out_valid, fifo_count}) | out_data, '0);
        check("rst_ctrl", 128'({busy, drain_finished, start_err}), '0);
        n_rst = 1'b1;
        tick();

        // Basic drain of three blocks with the consumer always ready.
        sram[16] <= 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
        sram[17] <= 128'hBBBB_7777_8888_9999_0000_1212_3434_5656;
        sram[18] <= 128'hCCCC_DEAD_BEEF_0123_4567_89AB_CDEF_F00D;
        out_ready = 1'b1;
        clear_logs();
        start(4'd3);
        check("t1_wait_no_read", 128'(sramRead), '0);
        check("t1_busy", 128'(busy), 128'(1));
        tick();
        check("t1_first_read", 128'(sramRead), 128'(1));
        check("t1_first_addr", 128'(sramAddr), 128'(16'h0010));
        wait_finish(40);
        check("t1_idle", 128'(busy), '0);
        check("t1_nreads", 128'(rd_log.size()), 128'(3));
        for (int i = 0; i < 3; i++) check("t1_addr", 128'(rd_log[i]), 128'(16 + i));
        check("t1_npops", 128'(pop_log.size()), 128'(3));
        check("t1_pop_a", pop_log[0], 128'hAAAA_0000_1111_2222_3333_4444_5555_6666);
        check("t1_pop_b", pop_log[1], 128'hBBBB_7777_8888_9999_0000_1212_3434_5656);
        check("t1_pop_c", pop_log[2], 128'hCCCC_DEAD_BEEF_0123_4567_89AB_CDEF_F00D);

        // Backpressure: six blocks into a four-entry FIFO with no consumer.
        preload(128'hD000);
        out_ready = 1'b0;
        clear_logs();
        f0 = fin_cnt;
        start(4'd6);
        repeat (30) tick();
        check("t2_count_full", 128'(fifo_count), 128'(4));
        check("t2_busy_hold", 128'(busy), 128'(1));
        check("t2_no_read", 128'(sramRead), '0);
        check("t2_nreads", 128'(rd_log.size()), 128'(4));
        check("t2_head", out_data, 128'hD000);
        check("t2_no_finish", 128'(fin_cnt - f0), '0);
        out_ready = 1'b1;
        wait_finish(60);
        repeat (4) tick();
        check("t2_npops", 128'(pop_log.size()), 128'(6));
        for (int i = 0; i < 6; i++) check("t2_pop", pop_log[i], 128'hD000 + 128'(i));
        check("t2_empty", 128'(fifo_count), '0);

        // Zero-length drain finishes two cycles after the start pulse.
        clear_logs();
        start(4'd0);
        check("t3_fin_early", 128'(drain_finished), '0);
        tick();
        check("t3_fin", 128'(drain_finished), 128'(1));
        check("t3_idle", 128'(busy), '0);
        tick();
        check("t3_fin_pulse", 128'(drain_finished), '0);
        check("t3_no_read", 128'(rd_log.size()), '0);

        // Start while busy flags an error and leaves the running drain alone.
        preload(128'hE000);
        out_ready = 1'b1;
        clear_logs();
        start(4'd2);
        drain_enable = 1'b1;
        nblocks      = 4'd5;
        tick();
        drain_enable = 1'b0;
        check("t4_err", 128'(start_err), 128'(1));
        tick();
        check("t4_err_pulse", 128'(start_err), '0);
        wait_finish(30);
        check("t4_nreads", 128'(rd_log.size()), 128'(2));
        check("t4_npops", 128'(pop_log.size()), 128'(2));
        check("t4_pop1", pop_log[1], 128'hE001);

        // Reset after the first of three blocks has been captured.
        preload(128'hF000);
        out_ready = 1'b0;
        clear_logs();
        start(4'd3);
        tick();
        tick();
        check("t5_one_block", 128'(fifo_count), 128'(1));
        n_rst = 1'b0;
        #1;
        check("t5_bus_clear", 128'({sramRead, sramAddr}), '0);
        check("t5_fifo_clear", 128'({out_valid, fifo_count}) | out_data, '0);
        check("t5_not_busy", 128'(busy), '0);
        f0 = fin_cnt;
        tick();
        tick();
        n_rst = 1'b1;
        repeat (10) tick();
        check("t5_no_finish", 128'(fin_cnt - f0), '0);
        check("t5_stay_idle", 128'(busy), '0);

`ifdef DRAIN_SCRUB_EN
        // Scrub: each read is followed by a zero write to the same address.
        preload(128'h5C00);
        out_ready = 1'b0;
        clear_logs();
        start(4'd2);
        wait_finish(30);
        check("t6_nwrites", 128'(wr_log.size()), 128'(2));
        check("t6_waddr0", 128'(wr_log[0]), 128'(16'h0010));
        check("t6_waddr1", 128'(wr_log[1]), 128'(16'h0011));
        check("t6_wiped0", sram[16], '0);
        check("t6_wiped1", sram[17], '0);
        check("t6_count", 128'(fifo_count), 128'(2));
        check("t6_head", out_data, 128'h5C00);
        out_ready = 1'b1;
        repeat (4) tick();
        check("t6_npops", 128'(pop_log.size()), 128'(2));
        check("t6_pop1", pop_log[1], 128'h5C01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
